// File: rtl/id_ex_pipe_reg.sv
// ID-to-EXE pipeline register with one-entry skid buffer, flush and bubble insertion.
// Optional stall counter built only when ID_EX_PERF_EN is defined.
module id_ex_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int REG_W     = 5,
    parameter int EXE_CMD_W = 6,
    parameter int MEM_CMD_W = 2,
    parameter int CTRL_W    = 1 + MEM_CMD_W + EXE_CMD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [3*XLEN-1:0]    opnd_in,
    input  logic [3*REG_W-1:0]   regs_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic [XLEN-1:0]      pc_out,
    output logic [3*XLEN-1:0]    opnd_out,
    output logic [3*REG_W-1:0]   regs_out,
    output logic [31:0]          stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0]  ctrl;
        logic [XLEN-1:0]    pc;
        logic [3*XLEN-1:0]  opnd;
        logic [3*REG_W-1:0] regs;
    } bndl_t;

    bndl_t r_main;
    bndl_t r_skid;
    logic  r_out_valid;
    logic  r_skid_valid;
    logic  r_in_ready;

    bndl_t w_in;
    logic  w_acc;
    logic  w_main_free;

    assign w_in        = {ctrl_in, pc_in, opnd_in, regs_in};
    assign w_acc       = in_valid & r_in_ready;
    assign w_main_free = ~r_out_valid | out_ready;

    // in_ready is kept as its own flop so ID never sees a path from EXE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= w_acc;
                r_in_ready   <= ~w_acc;
                if (w_acc) begin
                    r_skid <= w_in;
                end
            end else if (w_acc) begin
                r_main      <= w_in;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
                r_main.ctrl <= '0;
            end
        end else if (w_acc) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign ctrl_out  = r_main.ctrl;
    assign pc_out    = r_main.pc;
    assign opnd_out  = r_main.opnd;
    assign regs_out  = r_main.regs;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && r_stall_cnt != 32'hFFFF_FFFF) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed vector table plus random traffic vs a queue model.
module tb_id_ex_pipe_reg;

`ifdef ID_EX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] pc;
        logic [95:0] opnd;
        logic [14:0] regs;
    } bund_t;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          iv;
        bit          ordy;
        logic [31:0] pc;
        logic [8:0]  ctrl;
        bit          e_ov;
        bit          e_ir;
        logic [31:0] e_pc;
        logic [8:0]  e_ctrl;
        int          e_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  ctrl_in;
    logic [31:0] pc_in;
    logic [95:0] opnd_in;
    logic [14:0] regs_in;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  ctrl_out;
    logic [31:0] pc_out;
    logic [95:0] opnd_out;
    logic [14:0] regs_out;
    logic [31:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    bund_t       q[$];
    bund_t       last;
    int unsigned m_stall;

    id_ex_pipe_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl_in   (ctrl_in),
        .pc_in     (pc_in),
        .opnd_in   (opnd_in),
        .regs_in   (regs_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl_out  (ctrl_out),
        .pc_out    (pc_out),
        .opnd_out  (opnd_out),
        .regs_out  (regs_out),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Behavioural model: up to two bundles in flight, FIFO order
    task automatic model_edge();
        bund_t cur;
        bit    acc;
        bit    pop;
        cur = {ctrl_in, pc_in, opnd_in, regs_in};
        if (!rst) begin
            q.delete();
            last    = '0;
            m_stall = 0;
        end else begin
            if (PERF && q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF)
                m_stall++;
            if (flush) begin
                q.delete();
                last = '0;
            end else begin
                acc = in_valid && q.size() < 2;
                pop = q.size() > 0 && out_ready;
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(cur);
                if (q.size() > 0) last = q[0];
            end
        end
    endtask

    task automatic step();
        bit ov;
        @(posedge clk);
        model_edge();
        #1;
        ov = q.size() > 0;
        chk("out_valid", 128'(out_valid), 128'(ov));
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("ctrl_out", 128'(ctrl_out), ov ? 128'(last.ctrl) : 128'd0);
        chk("pc_out", 128'(pc_out), 128'(last.pc));
        chk("opnd_out", 128'(opnd_out), 128'(last.opnd));
        chk("regs_out", 128'(regs_out), 128'(last.regs));
        chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    endtask

    function automatic vec_t mk(bit r, bit f, bit iv, bit ordy, logic [31:0] pc,
                                logic [8:0] c, bit eov, bit eir, logic [31:0] epc,
                                logic [8:0] ec, int es);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy;
        v.pc = pc; v.ctrl = c;
        v.e_ov = eov; v.e_ir = eir; v.e_pc = epc; v.e_ctrl = ec; v.e_stall = es;
        return v;
    endfunction

    function automatic logic [95:0] f_opnd(logic [31:0] pc);
        return {pc ^ 32'hA5A5_0000, pc + 32'h10, ~pc};
    endfunction

    function automatic logic [14:0] f_regs(logic [31:0] pc);
        return {pc[4:0], pc[6:2], pc[9:5]};
    endfunction

    localparam logic [8:0] C = 9'h1C3;

    initial begin
        vec_t  tbl[$];
        bund_t pend;
        bit    have;
        bit    ir_pre;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ctrl_in = '0; pc_in = '0; opnd_in = '0; regs_in = '0;
        last = '0; m_stall = 0;

        // reset
        tbl.push_back(mk(0,0,0,0,0,0,      0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,      0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,      0,1,0,0,0));
        // streaming
        tbl.push_back(mk(1,0,1,1,32'h100,C, 1,1,32'h100,C,-1));
        tbl.push_back(mk(1,0,1,1,32'h104,C, 1,1,32'h104,C,-1));
        tbl.push_back(mk(1,0,1,1,32'h108,C, 1,1,32'h108,C,-1));
        tbl.push_back(mk(1,0,1,1,32'h10C,C, 1,1,32'h10C,C,-1));
        tbl.push_back(mk(1,0,0,1,0,0,       0,1,32'h10C,0,-1));
        // back-pressure
        tbl.push_back(mk(1,0,1,0,32'h200,C, 1,1,32'h200,C,-1));
        tbl.push_back(mk(1,0,1,0,32'h204,C, 1,0,32'h200,C,-1));
        tbl.push_back(mk(1,0,1,0,32'h208,C, 1,0,32'h200,C,-1));
        tbl.push_back(mk(1,0,1,1,32'h208,C, 1,1,32'h204,C,-1));
        tbl.push_back(mk(1,0,1,1,32'h208,C, 1,1,32'h208,C,-1));
        tbl.push_back(mk(1,0,0,1,0,0,       0,1,32'h208,0,-1));
        // flush with both slots full and a bundle offered
        tbl.push_back(mk(1,0,1,0,32'h300,C, 1,1,32'h300,C,-1));
        tbl.push_back(mk(1,0,1,0,32'h304,C, 1,0,32'h300,C,-1));
        tbl.push_back(mk(1,1,1,0,32'h308,C, 0,1,0,0,-1));
        tbl.push_back(mk(1,0,0,1,0,0,       0,1,0,0,-1));
        // bubble
        tbl.push_back(mk(1,0,1,1,32'h500,9'h10A, 1,1,32'h500,9'h10A,-1));
        tbl.push_back(mk(1,0,0,1,0,0,            0,1,32'h500,0,-1));
        // stall counter
        tbl.push_back(mk(0,0,0,1,0,0,       0,1,0,0,0));
        tbl.push_back(mk(1,0,1,0,32'h600,C, 1,1,32'h600,C,0));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(1,0,0,0,0,0,   1,1,32'h600,C,k));
        tbl.push_back(mk(1,1,0,1,0,0,       0,1,0,0,7));
        tbl.push_back(mk(1,0,0,1,0,0,       0,1,0,0,7));

        for (int i = 0; i < tbl.size(); i++) begin
            rst       = tbl[i].rst;
            flush     = tbl[i].flush;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            pc_in     = tbl[i].pc;
            ctrl_in   = tbl[i].ctrl;
            opnd_in   = f_opnd(tbl[i].pc);
            regs_in   = f_regs(tbl[i].pc);
            step();
            chk("tbl_out_valid", 128'(out_valid), 128'(tbl[i].e_ov));
            chk("tbl_in_ready", 128'(in_ready), 128'(tbl[i].e_ir));
            chk("tbl_pc_out", 128'(pc_out), 128'(tbl[i].e_pc));
            chk("tbl_ctrl_out", 128'(ctrl_out), 128'(tbl[i].e_ctrl));
            if (tbl[i].e_stall >= 0)
                chk("tbl_stall_cnt", 128'(stall_cnt),
                    PERF ? 128'(tbl[i].e_stall) : 128'd0);
        end

        // random traffic; source holds its bundle until accepted
        have = 1'b0;
        pend = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                pend.ctrl = 9'($urandom);
                pend.pc   = $urandom;
                pend.opnd = {$urandom, $urandom, $urandom};
                pend.regs = 15'($urandom);
                have      = 1'b1;
            end
            rst       = $urandom_range(0, 199) != 0;
            flush     = $urandom_range(0, 19) == 0;
            in_valid  = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < 6;
            {ctrl_in, pc_in, opnd_in, regs_in} = pend;
            ir_pre = q.size() < 2;
            step();
            if ((in_valid && ir_pre) || flush || !rst)
                have = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
